// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the command master and the slave-side blocks.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

endpackage

// File: rtl/ahb_cmd_master_if.sv
// Command/response stream plus AHB-Lite master bus signals of ahb_cmd_master.
interface ahb_cmd_master_if;
  import ahb_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_write;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  logic [31:0] HADDR;
  htrans_e     HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    input  HREADY, HRDATA, HRESP,
    output cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata,
    output HADDR, HTRANS, HSIZE, HWRITE, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    output HREADY, HRDATA, HRESP,
    input  cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata,
    input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA
  );

endinterface

// File: rtl/ahb_lane_mux.sv
// Byte-lane helper: replicates right-justified write data across lanes and
// extracts/extends the addressed lane of read data.
module ahb_lane_mux
  import ahb_pkg::*;
#(
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic [1:0]  wr_size,
  input  logic [31:0] wr_data,
  output logic [31:0] wr_lanes,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] rd_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // NOTE: every combinational output gets a default before the case so no path can infer a latch.
  always_comb begin
    wr_lanes = wr_data;
    case ({1'b0, wr_size})
      HSIZE_BYTE: wr_lanes = {4{wr_data[7:0]}};
      HSIZE_HALF: wr_lanes = {2{wr_data[15:0]}};
      default:    wr_lanes = wr_data;
    endcase
  end

  assign rd_byte = rd_data[{rd_addr, 3'b000} +: 8];
  assign rd_half = rd_addr[1] ? rd_data[31:16] : rd_data[15:0];

  always_comb begin
    rd_ext = rd_data;
    case ({1'b0, rd_size})
      HSIZE_BYTE: rd_ext = {{24{SIGN_EXT & rd_byte[7]}}, rd_byte};
      HSIZE_HALF: rd_ext = {{16{SIGN_EXT & rd_half[15]}}, rd_half};
      default:    rd_ext = rd_data;
    endcase
  end

endmodule

// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-transfer initiator: turns a valid/ready command stream into
// pipelined NONSEQ transfers, one address phase and one data phase in flight.
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_cmd_master_if.master bus
);

  logic        a_valid;
  logic [31:0] a_addr;
  logic [1:0]  a_size;
  logic        a_write;
  logic [31:0] a_wdata;

  logic        d_valid;
  logic        d_write;
  logic [1:0]  d_size;
  logic [1:0]  d_addr_lo;
  logic [31:0] hwdata_q;

  logic        rsp_valid_q;
  logic        rsp_write_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        accept;
  logic        a_done;
  logic        d_done;
  logic [31:0] wr_lanes;
  logic [31:0] rd_ext;

  // A held address phase blocks new commands only while the slave stalls.
  assign bus.cmd_ready = !a_valid || bus.HREADY;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign a_done        = a_valid && bus.HREADY;
  assign d_done        = d_valid && bus.HREADY;

  ahb_lane_mux #(.SIGN_EXT(SIGN_EXT)) u_lane_mux (
    .wr_size  (a_size),
    .wr_data  (a_wdata),
    .wr_lanes (wr_lanes),
    .rd_size  (d_size),
    .rd_addr  (d_addr_lo),
    .rd_data  (bus.HRDATA),
    .rd_ext   (rd_ext)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
      a_size  <= '0;
      a_write <= 1'b0;
      a_wdata <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_addr  <= bus.cmd_addr;
      a_size  <= bus.cmd_size;
      a_write <= bus.cmd_write;
      a_wdata <= bus.cmd_wdata;
    end else if (a_done) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      d_size    <= '0;
      d_addr_lo <= '0;
      hwdata_q  <= '0;
    end else if (a_done) begin
      d_valid   <= 1'b1;
      d_write   <= a_write;
      d_size    <= a_size;
      d_addr_lo <= a_addr[1:0];
      hwdata_q  <= wr_lanes;
    end else if (d_done) begin
      d_valid   <= 1'b0;
    end
  end

  // The first ERROR cycle has HREADY low, so only the closing cycle is captured.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= d_done;
      if (d_done) begin
        rsp_write_q <= d_write;
        rsp_err_q   <= (bus.HRESP == HRESP_ERROR);
        rsp_rdata_q <= d_write ? '0 : rd_ext;
      end
    end
  end

  assign bus.HADDR     = a_addr;
  assign bus.HTRANS    = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HSIZE     = {1'b0, a_size};
  assign bus.HWRITE    = a_write;
  assign bus.HWDATA    = hwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Scoreboard bench for ahb_cmd_master: two instances (zero- and sign-extending)
// share one stimulus stream and one scripted AHB slave.
module tb_ahb_cmd_master;
  import ahb_pkg::*;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b1;
  always #5 HCLK = ~HCLK;

  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr  = '0;
  logic [31:0] cmd_wdata = '0;
  logic [1:0]  cmd_size  = '0;
  logic        s_hready;
  logic        s_hresp;
  logic [31:0] s_hrdata;

  ahb_cmd_master_if if0 ();
  ahb_cmd_master_if if1 ();

  assign if0.cmd_valid = cmd_valid;  assign if1.cmd_valid = cmd_valid;
  assign if0.cmd_write = cmd_write;  assign if1.cmd_write = cmd_write;
  assign if0.cmd_addr  = cmd_addr;   assign if1.cmd_addr  = cmd_addr;
  assign if0.cmd_size  = cmd_size;   assign if1.cmd_size  = cmd_size;
  assign if0.cmd_wdata = cmd_wdata;  assign if1.cmd_wdata = cmd_wdata;
  assign if0.HREADY    = s_hready;   assign if1.HREADY    = s_hready;
  assign if0.HRESP     = s_hresp;    assign if1.HRESP     = s_hresp;
  assign if0.HRDATA    = s_hrdata;   assign if1.HRDATA    = s_hrdata;

  ahb_cmd_master #(.SIGN_EXT(1'b0)) dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if0.master));
  ahb_cmd_master #(.SIGN_EXT(1'b1)) dut1 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if1.master));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scripted slave: one entry per transfer, consumed as its address phase completes.
  typedef struct { int waits; logic err; logic [31:0] rdata; } slv_t;
  slv_t slv_q[$];
  slv_t cur;
  logic dp_active;
  int   dp_cnt;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_active <= 1'b0;
      dp_cnt    <= 0;
    end else if (s_hready) begin
      if (if0.HTRANS == HTRANS_NONSEQ) begin
        dp_active <= 1'b1;
        dp_cnt    <= 0;
        if (slv_q.size() > 0) cur <= slv_q.pop_front();
        else cur <= '{waits: 0, err: 1'b0, rdata: 32'h0};
      end else begin
        dp_active <= 1'b0;
      end
    end else if (dp_active) begin
      dp_cnt <= dp_cnt + 1;
    end
  end

  always_comb begin
    s_hready = 1'b1;
    s_hresp  = 1'b0;
    s_hrdata = '0;
    if (dp_active) begin
      s_hrdata = cur.rdata;
      if (dp_cnt < cur.waits) begin
        s_hready = 1'b0;
      end else if (cur.err && dp_cnt == cur.waits) begin
        s_hready = 1'b0;
        s_hresp  = 1'b1;
      end else begin
        s_hresp  = cur.err;
      end
    end
  end

  always @(posedge HCLK)
    if (HRESETn && cmd_valid && if0.cmd_ready)
      assert (cmd_size != 2'd3 &&
              !(cmd_size == 2'd1 && cmd_addr[0]) &&
              !(cmd_size == 2'd2 && cmd_addr[1:0] != 2'b00))
      else $error("illegal command size/alignment addr=%h size=%0d", cmd_addr, cmd_size);

  // Scoreboard monitor.
  typedef struct { logic is_write; logic err; logic [31:0] rd0; logic [31:0] rd1; } exp_t;
  exp_t exp_q[$];
  int cyc = 0;
  int rsp_count = 0;
  int run = 0;
  int last_cyc = -10;

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(negedge HCLK) begin
    exp_t e;
    if (if0.rsp_valid) begin
      rsp_count++;
      run = (cyc == last_cyc + 1) ? run + 1 : 1;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_write",    if0.rsp_write, e.is_write);
        check("rsp_err",      if0.rsp_err,   e.err);
        check("rsp_rdata",    if0.rsp_rdata, e.rd0);
        check("rsp_valid_sx", if1.rsp_valid, 1'b1);
        check("rsp_rdata_sx", if1.rsp_rdata, e.rd1);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] addr, input logic wr, input logic [1:0] sz,
                      input logic [31:0] wd, input int waits, input logic err,
                      input logic [31:0] hrdata, input logic [31:0] rd0,
                      input logic [31:0] rd1, input bit expect_rsp = 1'b1);
    bit ok = 1'b0;
    bit rdy;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_size  = sz;
    cmd_wdata = wd;
    slv_q.push_back('{waits: waits, err: err, rdata: hrdata});
    if (expect_rsp) exp_q.push_back('{is_write: wr, err: err, rd0: rd0, rd1: rd1});
    for (int i = 0; i < 50; i++) begin
      rdy = if0.cmd_ready;
      @(posedge HCLK);
      @(negedge HCLK);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge HCLK);
    check("drain", exp_q.size(), 32'd0);
    repeat (2) @(negedge HCLK);
  endtask

  initial begin
    int rc0;
    logic [31:0] a;
    logic [31:0] d;

    #1 HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    check("rst_htrans",    if0.HTRANS,    HTRANS_IDLE);
    check("rst_haddr",     if0.HADDR,     32'h0);
    check("rst_hsize",     if0.HSIZE,     3'd0);
    check("rst_hwrite",    if0.HWRITE,    1'b0);
    check("rst_hwdata",    if0.HWDATA,    32'h0);
    check("rst_rsp_valid", if0.rsp_valid, 1'b0);
    check("rst_rsp_rdata", if0.rsp_rdata, 32'h0);
    check("rst_cmd_ready", if0.cmd_ready, 1'b1);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Word write then read back.
    send(32'h4000_0000, 1'b1, 2'd2, 32'h000D_EEEE, 0, 1'b0, 32'h0, 32'h0, 32'h0);
    cmd_valid = 1'b0;
    check("w_htrans_ns", if0.HTRANS, HTRANS_NONSEQ);
    check("w_haddr",     if0.HADDR,  32'h4000_0000);
    check("w_hwrite",    if0.HWRITE, 1'b1);
    check("w_hsize",     if0.HSIZE,  3'd2);
    @(negedge HCLK);
    check("w_htrans_idle", if0.HTRANS, HTRANS_IDLE);
    check("w_hwdata",      if0.HWDATA, 32'h000D_EEEE);
    drain();
    send(32'h4000_0000, 1'b0, 2'd2, 32'h0, 0, 1'b0, 32'h000D_EEEE, 32'h000D_EEEE, 32'h000D_EEEE);
    cmd_valid = 1'b0;
    drain();

    // Sub-word write replication and read extraction.
    send(32'h4200_0005, 1'b1, 2'd0, 32'h0000_00DD, 0, 1'b0, 32'h0, 32'h0, 32'h0);
    cmd_valid = 1'b0;
    check("b_hsize", if0.HSIZE, 3'd0);
    @(negedge HCLK);
    check("b_hwdata", if0.HWDATA, 32'hDDDD_DDDD);
    drain();
    send(32'h4200_0005, 1'b0, 2'd0, 32'h0, 0, 1'b0, 32'h0000_DD00, 32'h0000_00DD, 32'hFFFF_FFDD);
    send(32'h4200_0006, 1'b0, 2'd1, 32'h0, 0, 1'b0, 32'h8001_0000, 32'h0000_8001, 32'hFFFF_8001);
    cmd_valid = 1'b0;
    drain();

    // Four back-to-back reads, zero-wait slave.
    rc0 = rsp_count;
    for (int i = 0; i < 4; i++) begin
      a = 32'h4000_0100 + 32'(4 * i);
      d = 32'h1111_1111 * 32'(i + 1);
      send(a, 1'b0, 2'd2, 32'h0, 0, 1'b0, d, d, d);
      check("b2b_htrans", if0.HTRANS, HTRANS_NONSEQ);
      check("b2b_haddr",  if0.HADDR,  a);
    end
    cmd_valid = 1'b0;
    drain();
    check("b2b_count", 32'(rsp_count - rc0), 32'd4);
    check("b2b_run",   32'(run), 32'd4);

    // Wait states on the second of two pipelined writes, a read queued behind.
    send(32'h4000_0010, 1'b1, 2'd2, 32'hAAAA_0001, 0, 1'b0, 32'h0, 32'h0, 32'h0);
    send(32'h4000_0014, 1'b1, 2'd2, 32'hBBBB_0002, 3, 1'b0, 32'h0, 32'h0, 32'h0);
    send(32'h4000_0018, 1'b0, 2'd2, 32'h0, 0, 1'b0, 32'h0C0C_0C0C, 32'h0C0C_0C0C, 32'h0C0C_0C0C);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ws_cmd_ready", if0.cmd_ready, 1'b0);
      check("ws_haddr",     if0.HADDR,     32'h4000_0018);
      check("ws_hwdata",    if0.HWDATA,    32'hBBBB_0002);
      @(negedge HCLK);
    end
    drain();

    // Two-cycle ERROR response, followed by a queued read that completes OKAY.
    send(32'h5000_0000, 1'b0, 2'd2, 32'h0, 0, 1'b1, 32'h0, 32'h0, 32'h0);
    send(32'h5000_0004, 1'b0, 2'd2, 32'h0, 0, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    cmd_valid = 1'b0;
    drain();

    // Reset while the data phase is stalled: transfer abandoned, no response.
    send(32'h6000_0000, 1'b0, 2'd2, 32'h0, 20, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    cmd_valid = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check("rr_htrans",    if0.HTRANS,    HTRANS_IDLE);
    check("rr_haddr",     if0.HADDR,     32'h0);
    check("rr_hwdata",    if0.HWDATA,    32'h0);
    check("rr_rsp_valid", if0.rsp_valid, 1'b0);
    check("rr_cmd_ready", if0.cmd_ready, 1'b1);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (4) @(negedge HCLK);
    check("rr_no_rsp", if0.rsp_valid, 1'b0);
    send(32'h4000_0020, 1'b1, 2'd2, 32'hCAFE_F00D, 0, 1'b0, 32'h0, 32'h0, 32'h0);
    send(32'h4000_0020, 1'b0, 2'd2, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D);
    cmd_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ahb_cmd_master.md
Name: ahb_cmd_master

Overview:
- Single-master AHB-Lite initiator that converts a valid/ready command stream into pipelined AHB-Lite single transfers (HTRANS NONSEQ/IDLE only, no bursts).
- Sits directly upstream of the AHB/APB subsystem and drives its HADDR/HTRANS/HSIZE/HWRITE/HWDATA, consuming HREADY/HRDATA/HRESP.
- Replaces task-driven stimulus with synthesizable traffic generation.
- Handles sub-word lane replication and read-data extraction.

Parameters:
- SIGN_EXT, 0, 1 = sub-word reads sign-extended on rsp_rdata; 0 = zero-extended.

Ports:
- HCLK  in  1  bus clock, all logic on rising edge
- HRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_addr  in  32  byte address, naturally aligned to cmd_size
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  2  0 = byte, 1 = half, 2 = word (3 is illegal)
- cmd_wdata  in  32  write data, right-justified
- rsp_valid  out  1  one-cycle pulse per completed transfer, in command order
- rsp_write  out  1  direction of completed transfer
- rsp_err  out  1  HRESP error seen in data phase
- rsp_rdata  out  32  extracted read data; 0 for writes
- HADDR  out  32  AHB address
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10)
- HSIZE  out  3  {1'b0, size}
- HWRITE  out  1  AHB direction
- HWDATA  out  32  data-phase write data
- HREADY  in  1  bus ready
- HRDATA  in  32  read data
- HRESP  in  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset (async assert, sync release): HTRANS = IDLE; HADDR, HSIZE, HWRITE, HWDATA = 0; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; rsp_write = 0; internal a_valid = 0, d_valid = 0. Reset mid-transfer abandons the transfer; no response is emitted.
- Address-phase register (a_*) drives the HADDR/HTRANS/HSIZE/HWRITE outputs directly as registered outputs.
- cmd_ready = !a_valid | HREADY (combinational).
- Accept edge: load a_*, set HTRANS = NONSEQ. The command appears on the bus the cycle after acceptance.
- Edge with HREADY & a_valid: address phase completes.
  - Move direction, size and addr[1:0] into the data-phase register; set d_valid = 1.
  - Write data is replicated across lanes and registered onto HWDATA: byte = {4{b}}, half = {2{h}}, word as-is.
  - If no command is accepted on the same edge, HTRANS <= IDLE and a_valid <= 0.
  - Back-to-back commands overlap: address N+1 is presented during data phase N.
- Edge with HREADY & d_valid: data phase completes.
  - rsp_valid <= 1 for one cycle; rsp_write <= direction; rsp_err <= HRESP.
  - Read extraction uses the captured addr[1:0]: byte lane addr[1:0], half lane addr[1]. Result is zero- or sign-extended per SIGN_EXT.
  - Writes return rsp_rdata = 0.
  - d_valid clears unless a new data phase starts on the same edge.
- HREADY low: all a_* / d_* registers and bus outputs hold; HWDATA stable for the whole data phase.
- ERROR: the first ERROR cycle (HREADY = 0) is ignored; the response is taken on the HREADY = 1 ERROR cycle. An already-issued next address phase is not cancelled.
- Maximum of one address phase plus one data phase in flight.
- Throughput: 1 transfer/cycle with zero-wait slaves. Latency from accept to rsp_valid is 3 edges with zero waits.
- Illegal cmd_size = 3 or misaligned cmd_addr: no hardware check; the bench flags these with an assertion.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
  - HSIZE encodings (BYTE, HALF, WORD)
  - HRESP encodings (OKAY, ERROR)
- One sub-module, ahb_lane_mux: combinational write-lane replication and read-lane extraction/extension. It is reused by the slave-side blocks.

Test Plan:
- Write word 0x4000_0000 = 0x000D_EEEE, then read it back. Expected: HTRANS NONSEQ then IDLE; HWDATA 0x000D_EEEE in the data phase; read rsp_rdata = 0x000D_EEEE; rsp_err = 0.
- Byte write 0xDD to 0x4200_0005. Expected: HSIZE = 0, HWDATA = 0xDDDD_DDDD. Read byte with HRDATA = 0x0000_DD00: rsp_rdata = 0x0000_00DD; with SIGN_EXT = 1: 0xFFFF_FFDD.
- Four back-to-back reads with cmd_valid held high and a zero-wait slave. Expected: HTRANS NONSEQ for 4 consecutive cycles, 4 rsp_valid pulses on consecutive cycles, order preserved.
- Slave inserts 3 wait states on the 2nd of 2 pipelined writes. Expected: HADDR and HWDATA held stable; cmd_ready = 0 during waits; rsp_valid counts = 2.
- Two-cycle ERROR response to a read of 0x5000_0000. Expected: rsp_valid with rsp_err = 1; the following queued command still completes OKAY.
- HRESETn asserted while a data phase is stalled by HREADY = 0. Expected: outputs return to reset values immediately; no rsp_valid; new command after release works.
